// File: rtl/spw_stats_pkg.sv
// Shared types and register map for the SpaceWire statistics scanner.
// Optional CLEAR support is controlled by SPW_STATS_CLEAR_EN.
package spw_stats_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SETTLE,
      ST_CAPTURE,
      ST_CLEAR
   } state_e;

   localparam int ADDR_W = 4;

   localparam logic [ADDR_W-1:0] ADDR_STATUS  = 4'hE;
   localparam logic [ADDR_W-1:0] ADDR_CONTROL = 4'hF;

   localparam int CTRL_START = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_CLR   = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/spw_stats_scan_ctrl_snapshot_bank.sv
// Snapshot register file: one capture write port, one registered read port.
// Address decode by comparison keeps out-of-range reads harmless.
module spw_stats_snapshot_bank
   import spw_stats_pkg::*;
#(
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [N];
   logic [31:0] rdata_q;
   logic [31:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N; i++) begin
         if (raddr_i == ADDR_W'(i)) rd_mux = mem_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
         rdata_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (we_i && waddr_i == ADDR_W'(i)) mem_q[i] <= wdata_i;
         end
         if (re_i) rdata_q <= rd_mux;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/spw_stats_scan_ctrl.sv
// Statistics scan sequencer with Avalon-MM CSR/snapshot access.
// Define SPW_STATS_CLEAR_EN to add the post-scan counter-clear pulse.
module spw_stats_scan_ctrl
   import spw_stats_pkg::*;
#(
   parameter int NUM_STATS = 8,
   parameter int SEL_W     = 4,
   parameter int SETTLE    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic [SEL_W-1:0]  stat_sel,
   input  logic [31:0]       stat_data,
   output logic              stat_clear,
   output logic              scan_irq
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cont_q, cont_d;
   logic             done_q, done_d;
   logic [7:0]       scan_cnt_q, scan_cnt_d;
   logic             irq_q, irq_d;
   logic [31:0]      csr_rdata_q, csr_rdata_d;
   logic             rd_snap_q, rd_snap_d;
   logic             clr_after_q;

   logic        wr_ctrl, wr_stat, is_snap;
   logic        last, scan_end, busy;
   logic [31:0] csr_rd, bank_rdata;

   assign wr_ctrl = avs_write && (avs_address == ADDR_CONTROL);
   assign wr_stat = avs_write && (avs_address == ADDR_STATUS);
   assign is_snap = avs_address < ADDR_W'(NUM_STATS);
   assign last    = idx_q == SEL_W'(NUM_STATS - 1);
   assign busy    = state_q != ST_IDLE;

`ifdef SPW_STATS_CLEAR_EN
   logic stat_clear_q;
   logic unused_wdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_after_q  <= 1'b0;
         stat_clear_q <= 1'b0;
      end else begin
         if (wr_ctrl) clr_after_q <= avs_writedata[CTRL_CLR];
         stat_clear_q <= state_d == ST_CLEAR;
      end
   end

   assign stat_clear   = stat_clear_q;
   assign unused_wdata = ^avs_writedata[31:3];
`else
   logic unused_wdata;

   assign clr_after_q  = 1'b0;
   assign stat_clear   = 1'b0;
   assign unused_wdata = ^avs_writedata[31:2];
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      cont_d     = wr_ctrl ? avs_writedata[CTRL_CONT] : cont_q;
      done_d     = done_q;
      scan_cnt_d = scan_cnt_q;
      irq_d      = 1'b0;
      scan_end   = 1'b0;

      if (wr_stat && avs_writedata[STAT_DONE]) done_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (wr_ctrl && avs_writedata[CTRL_START]) begin
               state_d = ST_SELECT;
               idx_d   = '0;
               sel_d   = '0;
            end
         end
         ST_SELECT: begin
            cnt_d   = '0;
            state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) state_d = ST_CAPTURE;
            else cnt_d = cnt_q + 1'b1;
         end
         ST_CAPTURE: begin
            if (!last) begin
               idx_d   = idx_q + 1'b1;
               sel_d   = idx_q + 1'b1;
               state_d = ST_SELECT;
            end else if (clr_after_q) begin
               state_d = ST_CLEAR;
            end else begin
               scan_end = 1'b1;
            end
         end
         ST_CLEAR: scan_end = 1'b1;
         default:  state_d  = ST_IDLE;
      endcase

      // a completing scan overrides a coincident DONE clear
      if (scan_end) begin
         irq_d      = 1'b1;
         done_d     = 1'b1;
         scan_cnt_d = scan_cnt_q + 8'd1;
         if (cont_q) begin
            state_d = ST_SELECT;
            idx_d   = '0;
            sel_d   = '0;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_comb begin
      csr_rd = '0;
      if (avs_address == ADDR_STATUS) begin
         csr_rd[STAT_BUSY]            = busy;
         csr_rd[STAT_DONE]            = done_q;
         csr_rd[STAT_CNT_LSB +: 8]    = scan_cnt_q;
      end else if (avs_address == ADDR_CONTROL) begin
         csr_rd[CTRL_CONT] = cont_q;
         csr_rd[CTRL_CLR]  = clr_after_q;
      end
      csr_rdata_d = avs_read ? csr_rd : csr_rdata_q;
      rd_snap_d   = avs_read ? is_snap : rd_snap_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         sel_q       <= '0;
         cnt_q       <= '0;
         cont_q      <= 1'b0;
         done_q      <= 1'b0;
         scan_cnt_q  <= '0;
         irq_q       <= 1'b0;
         csr_rdata_q <= '0;
         rd_snap_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         cont_q      <= cont_d;
         done_q      <= done_d;
         scan_cnt_q  <= scan_cnt_d;
         irq_q       <= irq_d;
         csr_rdata_q <= csr_rdata_d;
         rd_snap_q   <= rd_snap_d;
      end
   end

   spw_stats_snapshot_bank #(
      .N (NUM_STATS)
   ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (state_q == ST_CAPTURE),
      .waddr_i (ADDR_W'(idx_q)),
      .wdata_i (stat_data),
      .re_i    (avs_read && is_snap),
      .raddr_i (avs_address),
      .rdata_o (bank_rdata)
   );

   assign avs_readdata = rd_snap_q ? bank_rdata : csr_rdata_q;
   assign stat_sel     = sel_q;
   assign scan_irq     = irq_q;

endmodule

// File: tb/tb_spw_stats_scan_ctrl.sv
// Directed bench for spw_stats_scan_ctrl (default parameters).
// Clear-pulse expectations follow SPW_STATS_CLEAR_EN.
module tb_spw_stats_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic [3:0]  stat_sel;
   logic [31:0] stat_data;
   logic        stat_clear;
   logic        scan_irq;
   logic [31:0] base;

   int vec = 0;
   int err = 0;
   int cyc = 0;
   int clr_cnt = 0;
   int clr_cyc = 0;

   spw_stats_scan_ctrl dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .stat_sel      (stat_sel),
      .stat_data     (stat_data),
      .stat_clear    (stat_clear),
      .scan_irq      (scan_irq)
   );

   assign stat_data = base + {28'b0, stat_sel};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (stat_clear === 1'b1) begin
         clr_cnt++;
         clr_cyc = cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(posedge clk);
      #1;
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_address = a;
      avs_read    = 1'b1;
      @(posedge clk);
      #1;
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic wait_irq(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (scan_irq === 1'b1) begin
            at = cyc;
            break;
         end
      end
      vec++;
      if (at < 0) begin
         err++;
         $display("FAIL irq_timeout: got none, need scan_irq within %0d cycles", limit);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n       = 1'b0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_address   = '0;
      avs_writedata = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      @(posedge clk);
      #1;
      vec++;
      if ({avs_readdata, stat_sel, stat_clear, scan_irq} !== 38'd0) begin
         err++;
         $display("FAIL reset_outputs: got rd=%h sel=%h clr=%b irq=%b, need 0",
                  avs_readdata, stat_sel, stat_clear, scan_irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      rd(4'h0, d);
      vec++;
      if (d !== 32'h0) begin err++; $display("FAIL reset_snap0: got %h need 0", d); end
      rd(4'hE, d);
      vec++;
      if (d !== 32'h0) begin err++; $display("FAIL reset_status: got %h need 0", d); end
      rd(4'hF, d);
      vec++;
      if (d !== 32'h0) begin err++; $display("FAIL reset_control: got %h need 0", d); end
   endtask

   task automatic test_single_scan();
      logic [31:0] d;
      int t0, t1;
      base    = 32'h1000;
      clr_cnt = 0;
      wr(4'hF, 32'h1);
      t0 = cyc;
      wait_irq(100, t1);
      vec++;
      if (t1 - t0 !== 32) begin
         err++;
         $display("FAIL single_latency: got %0d need 32", t1 - t0);
      end
      @(posedge clk);
      #1;
      vec++;
      if (scan_irq !== 1'b0) begin
         err++;
         $display("FAIL irq_width: got %b need 0", scan_irq);
      end
      for (int i = 0; i < 8; i++) begin
         rd(4'(i), d);
         vec++;
         if (d !== 32'h1000 + i) begin
            err++;
            $display("FAIL snap%0d: got %h need %h", i, d, 32'h1000 + i);
         end
      end
      rd(4'hE, d);
      vec++;
      if (d !== 32'h0000_0102) begin err++; $display("FAIL single_status: got %h need 00000102", d); end
      wr(4'h0, 32'hDEAD_BEEF);
      rd(4'h0, d);
      vec++;
      if (d !== 32'h1000) begin err++; $display("FAIL snap_write_ignored: got %h need 00001000", d); end
      rd(4'h9, d);
      vec++;
      if (d !== 32'h0) begin err++; $display("FAIL unmapped_read: got %h need 0", d); end
      vec++;
      if (clr_cnt !== 0) begin err++; $display("FAIL single_no_clear: got %0d need 0", clr_cnt); end
   endtask

   task automatic test_continuous();
      logic [31:0] d;
      int prev, t;
      do_reset();
      base = 32'h2000;
      wr(4'hF, 32'h3);
      prev = cyc;
      for (int k = 0; k < 3; k++) begin
         wait_irq(100, t);
         vec++;
         if (t - prev !== 32) begin
            err++;
            $display("FAIL cont_gap%0d: got %0d need 32", k, t - prev);
         end
         prev = t;
      end
      wr(4'hF, 32'h0);
      wait_irq(100, t);
      vec++;
      if (t - prev !== 32) begin err++; $display("FAIL cont_last: got %0d need 32", t - prev); end
      repeat (40) @(posedge clk);
      rd(4'hE, d);
      vec++;
      if (d !== 32'h0000_0402) begin err++; $display("FAIL cont_status: got %h need 00000402", d); end
   endtask

   task automatic test_start_while_busy();
      logic [31:0] d;
      int t0, t1;
      base = 32'h3000;
      wr(4'hF, 32'h1);
      t0 = cyc;
      repeat (10) @(posedge clk);
      wr(4'hF, 32'h1);
      wait_irq(100, t1);
      vec++;
      if (t1 - t0 !== 32) begin err++; $display("FAIL busy_start: got %0d need 32", t1 - t0); end
      rd(4'hE, d);
      vec++;
      if (d !== 32'h0000_0502) begin err++; $display("FAIL busy_status: got %h need 00000502", d); end
      wr(4'hE, 32'h2);
      repeat (40) @(posedge clk);
      rd(4'hE, d);
      vec++;
      if (d !== 32'h0000_0500) begin err++; $display("FAIL done_w1c: got %h need 00000500", d); end
   endtask

   task automatic test_clear();
      logic [31:0] d;
      int t0, t1;
      clr_cnt = 0;
      wr(4'hF, 32'h5);
      t0 = cyc;
      wait_irq(100, t1);
      rd(4'hF, d);
`ifdef SPW_STATS_CLEAR_EN
      vec++;
      if (t1 - t0 !== 33) begin err++; $display("FAIL clear_latency: got %0d need 33", t1 - t0); end
      vec++;
      if (clr_cnt !== 1) begin err++; $display("FAIL clear_width: got %0d need 1", clr_cnt); end
      vec++;
      if (clr_cyc !== t0 + 32) begin
         err++;
         $display("FAIL clear_cycle: got %0d need %0d", clr_cyc - t0, 32);
      end
      vec++;
      if (d !== 32'h4) begin err++; $display("FAIL clear_ctrl_rd: got %h need 4", d); end
`else
      vec++;
      if (t1 - t0 !== 32) begin err++; $display("FAIL clear_latency: got %0d need 32", t1 - t0); end
      vec++;
      if (clr_cnt !== 0) begin err++; $display("FAIL clear_absent: got %0d need 0", clr_cnt); end
      vec++;
      if (d !== 32'h0) begin err++; $display("FAIL clear_ctrl_rd: got %h need 0", d); end
`endif
      wr(4'hF, 32'h0);
   endtask

   task automatic test_reset_mid_scan();
      logic [31:0] d;
      int t0, t1;
      base = 32'h4000;
      wr(4'hF, 32'h3);
      repeat (13) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      vec++;
      if ({stat_sel, stat_clear, scan_irq, avs_readdata} !== 38'd0) begin
         err++;
         $display("FAIL midreset_outputs: got sel=%h clr=%b irq=%b rd=%h, need 0",
                  stat_sel, stat_clear, scan_irq, avs_readdata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      rd(4'hE, d);
      vec++;
      if (d !== 32'h0) begin err++; $display("FAIL midreset_status: got %h need 0", d); end
      rd(4'hF, d);
      vec++;
      if (d !== 32'h0) begin err++; $display("FAIL midreset_control: got %h need 0", d); end
      for (int i = 0; i < 8; i++) begin
         rd(4'(i), d);
         vec++;
         if (d !== 32'h0) begin err++; $display("FAIL midreset_snap%0d: got %h need 0", i, d); end
      end
      base = 32'hA500;
      wr(4'hF, 32'h1);
      t0 = cyc;
      wait_irq(100, t1);
      vec++;
      if (t1 - t0 !== 32) begin err++; $display("FAIL rescan_latency: got %0d need 32", t1 - t0); end
      for (int i = 0; i < 8; i++) begin
         rd(4'(i), d);
         vec++;
         if (d !== 32'hA500 + i) begin
            err++;
            $display("FAIL rescan_snap%0d: got %h need %h", i, d, 32'hA500 + i);
         end
      end
      rd(4'hE, d);
      vec++;
      if (d !== 32'h0000_0102) begin err++; $display("FAIL rescan_status: got %h need 00000102", d); end
   endtask

   initial begin
      reset_n       = 1'b0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_address   = '0;
      avs_writedata = '0;
      base          = 32'h0;
      repeat (3) @(negedge clk);
      test_reset();
      test_single_scan();
      test_continuous();
      test_start_while_busy();
      test_clear();
      test_reset_mid_scan();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/spw_stats_scan_ctrl.md
# spw_stats_scan_ctrl

Sequencer for the SpaceWire core's statistical-information counters. It steps a select index across every statistic, waits for the selected value to settle, and captures each 32-bit value into a snapshot bank. Software then reads one coherent set over an Avalon-MM slave. It sits between the SpW core's statistics mux and the Nios/Avalon fabric, in place of reading the raw counter port directly.

## Interface
- NUM_STATS, 8: number of statistics scanned; legal range 1..14.
- SEL_W, 4: width of `stat_sel`; must satisfy 2^SEL_W ≥ NUM_STATS.
- SETTLE, 2: wait cycles between a select change and capture; 0 is legal.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- avs_address  in  4  word address: 0..NUM_STATS-1 snapshots, 0xE STATUS, 0xF CONTROL.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  registered read data.
- stat_sel  out  SEL_W  statistic index driven to the SpW core.
- stat_data  in  32  selected statistic value from the SpW core.
- stat_clear  out  1  one-cycle counter-clear pulse to the SpW core.
- scan_irq  out  1  one-cycle pulse when a scan completes.

## Operation
- CONTROL register (0xF), read/write:
  - bit0 START is write-only, self-clearing, and reads 0.
  - bit1 CONT selects continuous scanning.
  - bit2 CLR_AFTER clears the counters after each scan (see Configuration).
- STATUS register (0xE):
  - bit0 BUSY, read-only.
  - bit1 DONE, sticky; writing 1 to it clears it (W1C).
  - bits[15:8] SCAN_CNT, read-only, 8-bit, wraps 255→0.
- Reads of unmapped addresses return 0. Writes to snapshot or unmapped addresses are ignored.
- State machine: IDLE → SELECT → SETTLE → CAPTURE → (CLEAR) → IDLE or SELECT.
  - IDLE: a START write moves to SELECT with idx=0. START while BUSY is ignored.
  - SELECT: `stat_sel` <= idx; lasts 1 cycle.
  - SETTLE: counts SETTLE cycles. Skipped when SETTLE=0.
  - CAPTURE: snap[idx] <= `stat_data`. If idx < NUM_STATS-1, idx++ and go to SELECT. Otherwise the scan ends.
- At scan end:
  - Go to CLEAR if enabled and CLR_AFTER=1.
  - Set DONE, increment SCAN_CNT, pulse `scan_irq`.
  - Then go to SELECT with idx=0 if CONT=1, else to IDLE.
- Clearing CONT mid-scan lets the current scan finish, then the block goes to IDLE.
- If a DONE W1C write coincides with DONE being set, the set wins.
- BUSY = (state != IDLE).

## Timing
- Reset values:
  - `avs_readdata` 0.
  - `stat_sel` 0.
  - `stat_clear` 0.
  - `scan_irq` 0.
  - All snapshots 0, CONTROL 0, DONE 0, SCAN_CNT 0, state IDLE.
- Read latency is 1 cycle: `avs_readdata` is registered on the edge where `avs_read` is sampled high. It holds its value otherwise.
- A read of snap[i] in the same cycle as CAPTURE of snap[i] returns the old value.
- START written at edge T: SELECT occupies cycle T+1 and `stat_sel`=0 is visible from T+1.
- Each statistic takes SETTLE+2 cycles.
- A scan takes NUM_STATS×(SETTLE+2) cycles, plus 1 for CLEAR. With defaults that is 32 cycles.
- `scan_irq`, DONE and SCAN_CNT all update on the edge leaving the last CAPTURE (or CLEAR).
- In continuous mode the next SELECT follows with no gap.
- Asserting reset mid-scan aborts immediately and returns every register to its reset value.

## Configuration
- `SPW_STATS_CLEAR_EN` defined:
  - CONTROL bit2 CLR_AFTER is implemented.
  - When set, the CLEAR state drives `stat_clear`=1 for exactly one cycle after the final CAPTURE.
- Not defined:
  - No CLEAR state.
  - `stat_clear` is tied 0.
  - CONTROL bit2 is not stored and reads 0.
  - Scan length is exactly NUM_STATS×(SETTLE+2).

## Structure
- Package `spw_stats_pkg` holds:
  - the state enum (IDLE, SELECT, SETTLE, CAPTURE, CLEAR);
  - address constants ADDR_STATUS=4'hE and ADDR_CONTROL=4'hF;
  - CONTROL/STATUS bit-position constants.
- One sub-module, `spw_stats_snapshot_bank`: NUM_STATS×32 register file with one write port (capture) and one registered read port.
- The FSM, CONTROL/STATUS registers and the Avalon decode live in the top module.

## Test plan
- Reset, then read 0x0, 0xE and 0xF → all return 0. `stat_sel`=0 and `stat_clear`=0.
- Model `stat_data` = 0x1000+`stat_sel`; write CONTROL=0x1:
  - snap[0..7] read 0x1000..0x1007;
  - `scan_irq` pulses exactly 32 cycles after the write;
  - STATUS reads 0x0000_0102.
- Write CONTROL=0x3, let 3 scans run, then write CONTROL=0x0 → SCAN_CNT=4 after idle. There are no idle cycles between scans.
- START while BUSY → ignored; the scan completes at its original cycle. Then write STATUS=0x2 → DONE clears.
- With `SPW_STATS_CLEAR_EN` and CONTROL=0x5 → `stat_clear` is high for exactly 1 cycle after the last CAPTURE, and `scan_irq` fires 33 cycles after START. Without the macro, `stat_clear` never asserts.
- Assert reset_n low in the middle of a scan → BUSY=0, all outputs and snapshots return to 0, and the next START produces a full, correct scan.
